// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-address unit.
//   next_pc_sel_e : source chosen for the next fetch PC
//   INSTR_BYTES   : size of one instruction, used for the sequential increment
package pc_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_RET,
        SEL_REDIR,
        SEL_TRAP,
        SEL_RESET
    } next_pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, reset   : clock, synchronous active-high reset (clears count/pointer)
//   clear        : drop all entries (count -> 0)
//   push         : write push_data as the new top
//   pop          : discard the top (ignored when empty)
//   push+pop     : top replaced by push_data, count unchanged (empty -> plain push)
//   top          : current top entry
//   count        : number of valid entries, saturates at DEPTH
// Overflow wraps the pointer and overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [XLEN-1:0]            push_data,
    output logic [XLEN-1:0]            top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mem_q [DEPTH];
    logic            wr_en;
    logic [PW-1:0]   wr_idx;
    logic            pop_eff;

    always_comb begin
        pop_eff = pop && (count_q != '0);
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (clear) begin
            count_d = '0;
        end else if (pop_eff && push) begin
            // Pop then push lands on the same slot: overwrite in place.
            wr_en = 1'b1;
        end else if (push) begin
            ptr_d  = ptr_q + 1'b1;
            wr_idx = ptr_q + 1'b1;
            wr_en  = 1'b1;
            if (count_q != DepthCnt) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_eff) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Contents need no reset; only count qualifies them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign top   = mem_q[ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-address unit at the head of IF.
// Holds the fetch PC and picks the next one by fixed priority:
//   reset > trap > redirect > ret prediction > stall hold > sequential.
// A redirect to a target with nonzero low bits holds the PC and sets the
// sticky misaligned flag, which only reset or a trap clears.
// Optional feature macro: PC_RAS_EN (return-address stack for ret prediction).
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   stall                         : hold PC
//   trap_valid, trap_vector       : trap redirect (low bits not checked)
//   redirect_valid, redirect_target : EX-resolved redirect
//   call_valid, call_link         : push return address (PC_RAS_EN only)
//   ret_valid                     : pop/predict return (PC_RAS_EN only)
//   pc_out, pc_plus4              : current fetch PC and PC+4 (wrapping)
//   misaligned                    : sticky misaligned-redirect flag
//   ras_count                     : valid RAS entries (0 without PC_RAS_EN)
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        trap_valid,
    input  logic [XLEN-1:0]             trap_vector,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_target,
    input  logic                        call_valid,
    input  logic [XLEN-1:0]             call_link,
    input  logic                        ret_valid,
    output logic [XLEN-1:0]             pc_out,
    output logic [XLEN-1:0]             pc_plus4,
    output logic                        misaligned,
    output logic [$clog2(RAS_DEPTH):0]  ras_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misaligned_q, misaligned_d;
    next_pc_sel_e    sel;
    logic            redir_misaligned;
    logic            ret_hit;
    logic [XLEN-1:0] ras_top;

    assign pc_plus4         = pc_q + XLEN'(INSTR_BYTES);
    assign redir_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

`ifdef PC_RAS_EN
    logic ras_op_ok;
    logic ras_push;
    logic ras_pop;

    // Stack ops only commit when the instruction in ID is really advancing.
    assign ras_op_ok = !stall && !trap_valid && !redirect_valid;
    assign ras_push  = call_valid && ras_op_ok;
    assign ras_pop   = ret_valid && ras_op_ok;
    assign ret_hit   = ras_pop && (ras_count != '0);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_pc_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (trap_valid),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (call_link),
        .top       (ras_top),
        .count     (ras_count)
    );
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = ^{call_valid, ret_valid, call_link};
    assign ret_hit           = 1'b0;
    assign ras_top           = '0;
    assign ras_count         = '0;
`endif

    always_comb begin
        sel = SEL_SEQ;
        if (reset) begin
            sel = SEL_RESET;
        end else if (trap_valid) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = redir_misaligned ? SEL_HOLD : SEL_REDIR;
        end else if (ret_hit) begin
            sel = SEL_RET;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d = pc_q;
        unique case (sel)
            SEL_RESET: pc_d = RESET_VECTOR;
            SEL_TRAP:  pc_d = trap_vector;
            SEL_REDIR: pc_d = redirect_target;
            SEL_RET:   pc_d = ras_top;
            SEL_HOLD:  pc_d = pc_q;
            SEL_SEQ:   pc_d = pc_plus4;
            default:   pc_d = pc_q;
        endcase
    end

    always_comb begin
        misaligned_d = misaligned_q;
        if (trap_valid) begin
            misaligned_d = 1'b0;
        end else if (redir_misaligned) begin
            misaligned_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_out     = pc_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each step drives inputs, queues the expected
// post-edge state, clocks once and checks the popped expectation.
module tb_pc_unit;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            reset, stall, trap_valid, redirect_valid, call_valid, ret_valid;
    logic [XLEN-1:0] trap_vector, redirect_target, call_link;
    logic [XLEN-1:0] pc_out, pc_plus4;
    logic            misaligned;
    logic [2:0]      ras_count;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            mis;
        logic [2:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h1000),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .trap_valid      (trap_valid),
        .trap_vector     (trap_vector),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_valid      (call_valid),
        .call_link       (call_link),
        .ret_valid       (ret_valid),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .misaligned      (misaligned),
        .ras_count       (ras_count)
    );

    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic tv, input logic [XLEN-1:0] tvec,
                        input logic rdv, input logic [XLEN-1:0] rdt,
                        input logic cv, input logic [XLEN-1:0] cl, input logic rv,
                        input logic [XLEN-1:0] epc, input logic emis,
                        input logic [2:0] ecnt);
        exp_t e;
        reset           = rst;
        stall           = stl;
        trap_valid      = tv;
        trap_vector     = tvec;
        redirect_valid  = rdv;
        redirect_target = rdt;
        call_valid      = cv;
        call_link       = cl;
        ret_valid       = rv;
        e.pc  = epc;
        e.mis = emis;
        e.cnt = ecnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        assert (pc_out === e.pc) else begin
            n_fails++;
            $error("FAIL %s pc_out: got %h expected %h", tag, pc_out, e.pc);
        end
        n_checks++;
        assert (pc_plus4 === e.pc + 64'd4) else begin
            n_fails++;
            $error("FAIL %s pc_plus4: got %h expected %h", tag, pc_plus4, e.pc + 64'd4);
        end
        n_checks++;
        assert (misaligned === e.mis) else begin
            n_fails++;
            $error("FAIL %s misaligned: got %b expected %b", tag, misaligned, e.mis);
        end
        n_checks++;
        assert (ras_count === e.cnt) else begin
            n_fails++;
            $error("FAIL %s ras_count: got %0d expected %0d", tag, ras_count, e.cnt);
        end
    endtask

    // Shorthand: no trap, no redirect, no call/ret.
    task automatic idle(input string tag, input logic stl, input logic [XLEN-1:0] epc,
                        input logic emis, input logic [2:0] ecnt);
        step(tag, 0, stl, 0, '0, 0, '0, 0, '0, 0, epc, emis, ecnt);
    endtask

    initial begin
        //   tag          rst stl tv tvec      rdv rdt        cv cl       rv  exp pc    mis cnt
        step("reset",      1, 0, 0, '0,       0, '0,        0, '0,      0, 64'h1000, 0, 0);
        idle("seq0",          0,                                                64'h1004, 0, 0);
        idle("seq1",          0,                                                64'h1008, 0, 0);
        idle("stall",         1,                                                64'h1008, 0, 0);
        step("stl_redir",  0, 1, 0, '0,       1, 64'h2000,  0, '0,      0, 64'h2000, 0, 0);
        step("trap_win",   0, 0, 1, 64'h3000, 1, 64'h2000,  0, '0,      0, 64'h3000, 0, 0);
        step("misalign",   0, 0, 0, '0,       1, 64'h2002,  0, '0,      0, 64'h3000, 1, 0);
        idle("mis_sticky",    0,                                                64'h3004, 1, 0);
        step("trap_clr",   0, 0, 1, 64'h80,   0, '0,        0, '0,      0, 64'h80,   0, 0);
        step("stl_callret",0, 1, 0, '0,       0, '0,        1, 64'h104, 1, 64'h80,   0, 0);
`ifdef PC_RAS_EN
        step("call1",      0, 0, 0, '0,       0, '0,        1, 64'h104, 0, 64'h84,   0, 1);
        step("call2",      0, 0, 0, '0,       0, '0,        1, 64'h204, 0, 64'h88,   0, 2);
        step("ret1",       0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h204,  0, 1);
        step("ret2",       0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h104,  0, 0);
        step("ret_empty",  0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h108,  0, 0);
        step("push_a",     0, 0, 0, '0,       0, '0,        1, 64'h400, 0, 64'h10c,  0, 1);
        step("push_b",     0, 0, 0, '0,       0, '0,        1, 64'h500, 0, 64'h110,  0, 2);
        step("push_c",     0, 0, 0, '0,       0, '0,        1, 64'h600, 0, 64'h114,  0, 3);
        step("push_d",     0, 0, 0, '0,       0, '0,        1, 64'h700, 0, 64'h118,  0, 4);
        step("push_e",     0, 0, 0, '0,       0, '0,        1, 64'h800, 0, 64'h11c,  0, 4);
        step("pop_e",      0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h800,  0, 3);
        step("pop_d",      0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h700,  0, 2);
        step("pop_c",      0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h600,  0, 1);
        step("pop_b",      0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h500,  0, 0);
        step("cr_empty",   0, 0, 0, '0,       0, '0,        1, 64'h900, 1, 64'h504,  0, 1);
        step("cr_swap",    0, 0, 0, '0,       0, '0,        1, 64'ha00, 1, 64'h900,  0, 1);
        step("cr_stall",   0, 1, 0, '0,       0, '0,        1, 64'hb00, 1, 64'h900,  0, 1);
        step("ret_swapped",0, 0, 0, '0,       0, '0,        0, '0,      1, 64'ha00,  0, 0);
        step("call_c00",   0, 0, 0, '0,       0, '0,        1, 64'hc00, 0, 64'ha04,  0, 1);
        step("trap_clear", 0, 0, 1, 64'h80,   0, '0,        1, 64'hd00, 0, 64'h80,   0, 0);
`else
        step("ret_noras",  0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h84,   0, 0);
        step("call_noras", 0, 0, 0, '0,       0, '0,        1, 64'h104, 0, 64'h88,   0, 0);
        step("ret2_noras", 0, 0, 0, '0,       0, '0,        0, '0,      1, 64'h8c,   0, 0);
`endif
        step("to_top",     0, 0, 0, '0, 1, 64'hffff_ffff_ffff_fffc, 0, '0, 0,
             64'hffff_ffff_ffff_fffc, 0, 0);
        idle("wrap",          0,                                                64'h0,    0, 0);
        step("mis_again",  0, 0, 0, '0,       1, 64'h6001,  0, '0,      0, 64'h0,    1, 0);
        step("reset_mid",  1, 0, 1, 64'h80,   1, 64'h5000,  0, '0,      0, 64'h1000, 0, 0);
        idle("post_reset",    0,                                                64'h1004, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
